mem_stage_hs: RTL and testbench
===============================

Name: mem_stage_hs

Overview:
- Parametrised successor of the MEM pipeline stage. It sits between EXE and WB and drives a data RAM with split request/response timing: the EXE stage issues the request, and this stage waits any number of cycles for data_ok.
- Performs load extraction (byte/half/word, plus wu/d at 64-bit) with sign or zero extension.
- Buffers a response that returns while WB is stalled.
- Supports pipeline flush, discarding responses still in flight for cancelled loads.

Parameters:
- DATA_W, 32, data path width; legal values are 32 or 64.
- PC_W, 32, PC width.
- CANCEL_W, 2, width of the counter of responses still to discard.

Ports:
- clk  in  1  clock
- resetn  in  1  asynchronous active-low reset
- ws_allowin  in  1  WB can accept
- ms_allowin  out  1  MEM can accept
- es_to_ms_valid  in  1  EXE presents an instruction
- es_pc  in  PC_W  instruction PC
- es_alu_result  in  DATA_W  ALU result / load address
- es_dest  in  5  destination register
- es_gr_we  in  1  register write enable
- es_res_from_mem  in  1  instruction is a load
- es_req_sent  in  1  EXE issued a data request for this instruction
- es_ld_code  in  3  000 w, 001 b, 010 bu, 011 h, 100 hu, 101 wu, 110 d
- flush  in  1  cancel the instruction held in MEM
- data_sram_data_ok  in  1  read response valid (one per request, in order)
- data_sram_rdata  in  DATA_W  read data
- ms_to_ws_valid  out  1  result valid to WB
- ms_pc  out  PC_W  PC to WB
- ms_gr_we  out  1  write enable to WB
- ms_dest  out  5  destination to WB
- ms_final_result  out  DATA_W  load data or ALU result
- mem_waddr  out  5  forwarding destination, 0 when none
- mem_mem_result  out  DATA_W  forwarding value (equals ms_final_result)
- mem_fwd_pending  out  1  load in MEM has no data yet; consumer must stall

Behaviour:
- Reset (resetn low, asynchronous):
  - ms_valid=0, captured fields=0, state=IDLE, buffer empty, cancel_cnt=0.
  - Outputs: ms_allowin=1, ms_to_ws_valid=0, mem_waddr=0, mem_fwd_pending=0, all data outputs 0.
- Capture: when es_to_ms_valid && ms_allowin, all es_* fields are registered; ms_valid <= es_to_ms_valid whenever ms_allowin.
- Allow-in: ms_allowin = !ms_valid || (ms_ready_go && ws_allowin).
- Output valid: ms_to_ws_valid = ms_valid && ms_ready_go && !flush.
- Response acceptance: data_ok "belongs" to MEM only when cancel_cnt==0; otherwise it decrements cancel_cnt and is dropped.
- State machine, per instruction:
  - IDLE: no outstanding request. Entered on capture of an instruction with req_sent=0. ms_ready_go=1.
  - WAIT: entered on capture with req_sent=1. ms_ready_go = owned data_ok this cycle, with data taken combinationally from rdata.
    - Owned data_ok with ws_allowin=0 → HOLD: rdata is latched into the buffer.
    - Owned data_ok with ws_allowin=1 → retire.
  - HOLD: ms_ready_go=1 and data comes from the buffer. Leaves on retire.
  - Retire (ms_to_ws_valid && ws_allowin): go to IDLE, or directly to the next instruction's state if one is captured the same cycle.
- Flush: clears ms_valid and returns to IDLE.
  - If flushed in WAIT with no owned data_ok in the same cycle, cancel_cnt increments.
  - A simultaneous stale data_ok (cancel_cnt>0) and increment leave the count unchanged.
  - cancel_cnt saturates at max; upstream must not exceed it.
  - Flush in HOLD drops the buffer.
  - A flush cycle cannot capture a new instruction.
- Load extraction:
  - off = alu_result[log2(DATA_W/8)-1:0], aligned down to access size.
  - b/bu select byte off; h/hu select the halfword at off&~1; w/wu select the word at off&~3. Each is sign- or zero-extended to DATA_W.
  - d is full data, 64-bit only. For DATA_W=32, codes 101/110 behave as w.
  - Undefined codes 111 give 0.
- Final result: ms_final_result = res_from_mem ? extracted : alu_result.
- Forwarding:
  - mem_waddr = ms_dest when ms_valid && gr_we, else 0.
  - mem_fwd_pending = ms_valid && res_from_mem && state==WAIT && !owned data_ok.
- Retirement is strictly in order with one instruction in MEM. The buffer depth is 1.

Test Plan:
- ALU op, dest=5, alu_result=0x1234, ws_allowin=1 → ms_to_ws_valid the cycle after capture, result 0x1234, mem_waddr=5.
- lb at addr 0x...2, data_ok 3 cycles later with rdata=0x0080FF00 → mem_fwd_pending=1 for 3 cycles, then result 0xFFFFFF80; lhu at off 2 with the same data → 0x00000080.
- Load whose data_ok arrives while ws_allowin=0 for 2 cycles, rdata=0xDEADBEEF, lw → held in HOLD, then retires 0xDEADBEEF even though rdata has since changed to 0.
- Flush in WAIT, then a new lw (req_sent=1) captured. First data_ok (0xAAAA) is dropped and cancel_cnt returns to 0; second data_ok (0x5555) retires 0x5555.
- DATA_W=64: ld_code d at addr 0x8 with rdata=0x8000_0000_0000_0001 → 0x8000000000000001; wu at off 4 → 0x0000000080000000.
- Assert resetn low mid-WAIT → outputs 0 and ms_allowin=1 immediately, asynchronously; no retirement after release.

Source files
------------

// File: rtl/mem_stage_hs_if.sv
// EXE -> MEM -> WB handshake, data-RAM response and forwarding bundle of the MEM stage.
// The slave modport is the MEM stage's view; master is the surrounding pipeline.
interface mem_stage_hs_if #(
    parameter int DATA_W = 32,
    parameter int PC_W   = 32
);
    logic              ws_allowin;
    logic              ms_allowin;
    logic              es_to_ms_valid;
    logic [PC_W-1:0]   es_pc;
    logic [DATA_W-1:0] es_alu_result;
    logic [4:0]        es_dest;
    logic              es_gr_we;
    logic              es_res_from_mem;
    logic              es_req_sent;
    logic [2:0]        es_ld_code;
    logic              flush;
    logic              data_sram_data_ok;
    logic [DATA_W-1:0] data_sram_rdata;
    logic              ms_to_ws_valid;
    logic [PC_W-1:0]   ms_pc;
    logic              ms_gr_we;
    logic [4:0]        ms_dest;
    logic [DATA_W-1:0] ms_final_result;
    logic [4:0]        mem_waddr;
    logic [DATA_W-1:0] mem_mem_result;
    logic              mem_fwd_pending;

    modport slave (
        input  ws_allowin, es_to_ms_valid, es_pc, es_alu_result, es_dest, es_gr_we,
               es_res_from_mem, es_req_sent, es_ld_code, flush,
               data_sram_data_ok, data_sram_rdata,
        output ms_allowin, ms_to_ws_valid, ms_pc, ms_gr_we, ms_dest, ms_final_result,
               mem_waddr, mem_mem_result, mem_fwd_pending
    );

    modport master (
        output ws_allowin, es_to_ms_valid, es_pc, es_alu_result, es_dest, es_gr_we,
               es_res_from_mem, es_req_sent, es_ld_code, flush,
               data_sram_data_ok, data_sram_rdata,
        input  ms_allowin, ms_to_ws_valid, ms_pc, ms_gr_we, ms_dest, ms_final_result,
               mem_waddr, mem_mem_result, mem_fwd_pending
    );
endinterface

// File: rtl/mem_stage_hs.sv
// MEM pipeline stage with split request/response data RAM timing, a one-entry response
// buffer for WB stalls, load extraction, and discard of responses for flushed loads.
module mem_stage_hs #(
    parameter int DATA_W   = 32,
    parameter int PC_W     = 32,
    parameter int CANCEL_W = 2
) (
    input logic          clk,
    input logic          resetn,
    mem_stage_hs_if.slave ms
);

    localparam int OFF_W = $clog2(DATA_W / 8);
    localparam logic [OFF_W-1:0]    H_MASK     = ~OFF_W'(3'd1);
    localparam logic [OFF_W-1:0]    W_MASK     = ~OFF_W'(3'd3);
    localparam logic [CANCEL_W-1:0] CANCEL_MAX = '1;
    localparam logic [CANCEL_W-1:0] CANCEL_ONE = {{(CANCEL_W-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_HOLD = 2'd2
    } state_e;

    state_e              state_r;
    logic                ms_valid_r;
    logic [PC_W-1:0]     pc_r;
    logic [DATA_W-1:0]   alu_r;
    logic [4:0]          dest_r;
    logic                gr_we_r;
    logic                res_from_mem_r;
    logic [2:0]          ld_code_r;
    logic [DATA_W-1:0]   buf_r;
    logic [CANCEL_W-1:0] cancel_cnt_r;

    logic                owned_ok_s;
    logic                ready_go_s;
    logic                allowin_s;
    logic                out_valid_s;
    logic [DATA_W-1:0]   load_data_s;
    logic [DATA_W-1:0]   final_s;
    logic                cancel_inc_s;
    logic                cancel_dec_s;

    // Offset is aligned down to the access size; 101/110 fall back to a signed word at 32 bits.
    function automatic logic [DATA_W-1:0] load_extract(
        input logic [DATA_W-1:0] data,
        input logic [OFF_W-1:0]  off,
        input logic [2:0]        code
    );
        logic [DATA_W-1:0] b_sh;
        logic [DATA_W-1:0] h_sh;
        logic [DATA_W-1:0] w_sh;
        logic [7:0]        b;
        logic [15:0]       h;
        logic [31:0]       w;
        logic [DATA_W-1:0] res;
        b_sh = data >> {off, 3'b000};
        h_sh = data >> {off & H_MASK, 3'b000};
        w_sh = data >> {off & W_MASK, 3'b000};
        b    = b_sh[7:0];
        h    = h_sh[15:0];
        w    = w_sh[31:0];
        case (code)
            3'b000:  res = DATA_W'($signed(w));
            3'b001:  res = DATA_W'($signed(b));
            3'b010:  res = DATA_W'(b);
            3'b011:  res = DATA_W'($signed(h));
            3'b100:  res = DATA_W'(h);
            3'b101:  res = (DATA_W == 32'sd64) ? DATA_W'(w) : DATA_W'($signed(w));
            3'b110:  res = (DATA_W == 32'sd64) ? data : DATA_W'($signed(w));
            default: res = '0;
        endcase
        return res;
    endfunction

    // Handshake, response ownership and data path selection.
    always_comb begin
        owned_ok_s = ms.data_sram_data_ok && (cancel_cnt_r == '0);
        case (state_r)
            ST_IDLE: ready_go_s = 1'b1;
            ST_WAIT: ready_go_s = owned_ok_s;
            ST_HOLD: ready_go_s = 1'b1;
            default: ready_go_s = 1'b0;
        endcase
        if (state_r == ST_HOLD) begin
            load_data_s = buf_r;
        end else begin
            load_data_s = ms.data_sram_rdata;
        end
        if (res_from_mem_r) begin
            final_s = load_extract(load_data_s, alu_r[OFF_W-1:0], ld_code_r);
        end else begin
            final_s = alu_r;
        end
        allowin_s    = !ms_valid_r || (ready_go_s && ms.ws_allowin);
        out_valid_s  = ms_valid_r && ready_go_s && !ms.flush;
        cancel_inc_s = ms.flush && ms_valid_r && (state_r == ST_WAIT) && !owned_ok_s;
        cancel_dec_s = ms.data_sram_data_ok && (cancel_cnt_r != '0);
    end

    // Stage outputs and forwarding view.
    always_comb begin
        ms.ms_allowin      = allowin_s;
        ms.ms_to_ws_valid  = out_valid_s;
        ms.ms_pc           = pc_r;
        ms.ms_gr_we        = gr_we_r;
        ms.ms_dest         = dest_r;
        ms.ms_final_result = final_s;
        ms.mem_mem_result  = final_s;
        if (ms_valid_r && gr_we_r) begin
            ms.mem_waddr = dest_r;
        end else begin
            ms.mem_waddr = 5'd0;
        end
        ms.mem_fwd_pending = ms_valid_r && res_from_mem_r && (state_r == ST_WAIT) && !owned_ok_s;
    end

    // Instruction capture, per-instruction state machine and stale-response counter.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_r        <= ST_IDLE;
            ms_valid_r     <= 1'b0;
            pc_r           <= '0;
            alu_r          <= '0;
            dest_r         <= 5'd0;
            gr_we_r        <= 1'b0;
            res_from_mem_r <= 1'b0;
            ld_code_r      <= 3'd0;
            buf_r          <= '0;
            cancel_cnt_r   <= '0;
        end else begin
            // A stale response cancelling out a new cancellation leaves the count unchanged.
            if (cancel_inc_s && !cancel_dec_s && (cancel_cnt_r != CANCEL_MAX)) begin
                cancel_cnt_r <= cancel_cnt_r + CANCEL_ONE;
            end else if (cancel_dec_s && !cancel_inc_s) begin
                cancel_cnt_r <= cancel_cnt_r - CANCEL_ONE;
            end else begin
                cancel_cnt_r <= cancel_cnt_r;
            end

            if (ms.flush) begin
                ms_valid_r <= 1'b0;
                state_r    <= ST_IDLE;
            end else if (allowin_s) begin
                ms_valid_r <= ms.es_to_ms_valid;
                if (ms.es_to_ms_valid) begin
                    pc_r           <= ms.es_pc;
                    alu_r          <= ms.es_alu_result;
                    dest_r         <= ms.es_dest;
                    gr_we_r        <= ms.es_gr_we;
                    res_from_mem_r <= ms.es_res_from_mem;
                    ld_code_r      <= ms.es_ld_code;
                    state_r        <= ms.es_req_sent ? ST_WAIT : ST_IDLE;
                end else begin
                    state_r <= ST_IDLE;
                end
            end else if ((state_r == ST_WAIT) && owned_ok_s) begin
                state_r <= ST_HOLD;
                buf_r   <= ms.data_sram_rdata;
            end else begin
                state_r <= state_r;
            end
        end
    end

endmodule

// File: tb/tb_mem_stage_hs.sv
// Bench for mem_stage_hs: directed scenarios plus randomized traffic, checked every cycle
// against a transaction-level model (held instruction + queue of outstanding requests).
module tb_mem_stage_hs;

    logic clk;
    logic resetn;

    mem_stage_hs_if #(.DATA_W(32), .PC_W(32)) b32 ();
    mem_stage_hs_if #(.DATA_W(64), .PC_W(32)) b64 ();

    mem_stage_hs #(.DATA_W(32), .PC_W(32), .CANCEL_W(2)) u_dut32 (.clk(clk), .resetn(resetn), .ms(b32));
    mem_stage_hs #(.DATA_W(64), .PC_W(32), .CANCEL_W(2)) u_dut64 (.clk(clk), .resetn(resetn), .ms(b64));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Model: the instruction sitting in MEM, whether its data has arrived, and the
    // in-order list of outstanding requests (1 = belongs to a live load, 0 = cancelled).
    bit          m_valid;
    logic [31:0] m_pc, m_alu, m_data;
    logic [4:0]  m_dest;
    bit          m_we, m_load, m_req, m_have;
    logic [2:0]  m_code;
    bit          rq[$];

    bit          e_owned, e_ready, e_allow, e_ov;
    logic [31:0] e_data;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    function automatic logic [63:0] model_ext(input logic [63:0] data, input int dw,
                                              input logic [63:0] addr, input logic [2:0] code);
        int nb, off, sz;
        bit sgn;
        logic [63:0] v;
        nb = dw / 8;
        off = int'(addr[2:0]) % nb;
        case (code)
            3'd0: begin sz = 4; sgn = 1'b1; end
            3'd1: begin sz = 1; sgn = 1'b1; end
            3'd2: begin sz = 1; sgn = 1'b0; end
            3'd3: begin sz = 2; sgn = 1'b1; end
            3'd4: begin sz = 2; sgn = 1'b0; end
            3'd5: begin sz = 4; sgn = (dw == 32); end
            3'd6: begin sz = (dw == 64) ? 8 : 4; sgn = (dw == 32); end
            default: return 64'd0;
        endcase
        off = off - (off % sz);
        v = '0;
        for (int i = 0; i < sz; i++) v[8*i +: 8] = data[8*(off+i) +: 8];
        if (sgn && v[8*sz-1]) for (int i = sz; i < 8; i++) v[8*i +: 8] = 8'hFF;
        if (dw == 32) v[63:32] = '0;
        return v;
    endfunction

    function automatic int cancelled_cnt();
        int c = 0;
        foreach (rq[i]) if (!rq[i]) c++;
        return c;
    endfunction

    task automatic model_clear();
        m_valid = 0; m_have = 0; rq.delete();
    endtask

    task automatic model_eval();
        e_owned = b32.data_sram_data_ok && (rq.size() > 0) && rq[0];
        e_ready = m_req ? (m_have || e_owned) : 1'b1;
        e_data  = m_have ? m_data : b32.data_sram_rdata;
        e_allow = !m_valid || (e_ready && b32.ws_allowin);
        e_ov    = m_valid && e_ready && !b32.flush;
    endtask

    task automatic compare();
        logic [63:0] exp_res;
        model_eval();
        check("allowin", 64'(b32.ms_allowin), 64'(e_allow));
        check("to_ws_valid", 64'(b32.ms_to_ws_valid), 64'(e_ov));
        check("waddr", 64'(b32.mem_waddr), (m_valid && m_we) ? 64'(m_dest) : 64'd0);
        check("fwd_pending", 64'(b32.mem_fwd_pending), 64'(m_valid && m_load && m_req && !m_have && !e_owned));
        if (e_ov) begin
            exp_res = m_load ? model_ext(64'(e_data), 32, 64'(m_alu), m_code) : 64'(m_alu);
            check("final_result", 64'(b32.ms_final_result), exp_res);
            check("mem_result", 64'(b32.mem_mem_result), exp_res);
            check("pc", 64'(b32.ms_pc), 64'(m_pc));
            check("dest", 64'(b32.ms_dest), 64'(m_dest));
            check("gr_we", 64'(b32.ms_gr_we), 64'(m_we));
        end
    endtask

    task automatic model_update();
        if (!resetn) begin
            model_clear();
            return;
        end
        model_eval();
        if (b32.data_sram_data_ok && rq.size() > 0) void'(rq.pop_front());
        if (b32.flush) begin
            if (m_valid && m_req && !m_have && !e_owned) rq[rq.size()-1] = 1'b0;
            m_valid = 0; m_have = 0;
        end else if (e_allow) begin
            if (b32.es_to_ms_valid) begin
                m_valid = 1; m_have = 0;
                m_pc = b32.es_pc; m_alu = b32.es_alu_result; m_dest = b32.es_dest;
                m_we = b32.es_gr_we; m_load = b32.es_res_from_mem; m_req = b32.es_req_sent;
                m_code = b32.es_ld_code;
                if (b32.es_req_sent) rq.push_back(1'b1);
            end else begin
                m_valid = 0;
            end
        end else if (e_owned) begin
            m_have = 1; m_data = b32.data_sram_rdata;
        end
    endtask

    task automatic settle();
        @(negedge clk);
        compare();
    endtask

    task automatic advance();
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic idle();
        b32.ws_allowin = 1'b1; b32.es_to_ms_valid = 1'b0; b32.es_pc = '0; b32.es_alu_result = '0;
        b32.es_dest = '0; b32.es_gr_we = 1'b0; b32.es_res_from_mem = 1'b0; b32.es_req_sent = 1'b0;
        b32.es_ld_code = '0; b32.flush = 1'b0; b32.data_sram_data_ok = 1'b0; b32.data_sram_rdata = '0;
        b64.ws_allowin = 1'b1; b64.es_to_ms_valid = 1'b0; b64.es_pc = '0; b64.es_alu_result = '0;
        b64.es_dest = '0; b64.es_gr_we = 1'b0; b64.es_res_from_mem = 1'b0; b64.es_req_sent = 1'b0;
        b64.es_ld_code = '0; b64.flush = 1'b0; b64.data_sram_data_ok = 1'b0; b64.data_sram_rdata = '0;
    endtask

    task automatic present(input logic [31:0] pc, input logic [31:0] alu, input logic [4:0] dest,
                           input bit we, input bit load, input bit req, input logic [2:0] code);
        b32.es_to_ms_valid = 1'b1; b32.es_pc = pc; b32.es_alu_result = alu; b32.es_dest = dest;
        b32.es_gr_we = we; b32.es_res_from_mem = load; b32.es_req_sent = req; b32.es_ld_code = code;
    endtask

    task automatic present64(input logic [63:0] alu, input logic [2:0] code);
        b64.es_to_ms_valid = 1'b1; b64.es_pc = 32'h600; b64.es_alu_result = alu; b64.es_dest = 5'd9;
        b64.es_gr_we = 1'b1; b64.es_res_from_mem = 1'b1; b64.es_req_sent = 1'b1; b64.es_ld_code = code;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        model_clear();
        idle();
        resetn = 1'b0;
        settle();
        check("rst_allowin", 64'(b32.ms_allowin), 64'd1);
        check("rst_valid", 64'(b32.ms_to_ws_valid), 64'd0);
        check("rst_result", 64'(b32.ms_final_result), 64'd0);
        advance();
        resetn = 1'b1;

        // ALU op retires the cycle after capture.
        present(32'h100, 32'h1234, 5'd5, 1, 0, 0, 3'd0); settle(); advance();
        idle(); settle();
        check("alu_valid", 64'(b32.ms_to_ws_valid), 64'd1);
        check("alu_result", 64'(b32.ms_final_result), 64'h1234);
        check("alu_waddr", 64'(b32.mem_waddr), 64'd5);
        advance();

        // lb at offset 2, response three cycles late.
        present(32'h104, 32'h1002, 5'd7, 1, 1, 1, 3'd1); settle(); advance();
        idle();
        for (int i = 0; i < 3; i++) begin
            settle(); check("lb_pending", 64'(b32.mem_fwd_pending), 64'd1); advance();
        end
        b32.data_sram_data_ok = 1'b1; b32.data_sram_rdata = 32'h0080FF00; settle();
        check("lb_valid", 64'(b32.ms_to_ws_valid), 64'd1);
        check("lb_result", 64'(b32.ms_final_result), 64'hFFFFFF80);
        check("lb_pending_off", 64'(b32.mem_fwd_pending), 64'd0);
        advance();
        idle(); present(32'h108, 32'h1002, 5'd8, 1, 1, 1, 3'd4); settle(); advance();
        idle(); b32.data_sram_data_ok = 1'b1; b32.data_sram_rdata = 32'h0080FF00; settle();
        check("lhu_result", 64'(b32.ms_final_result), 64'h80);
        advance();

        // Response while WB stalls is held across rdata changing.
        idle(); present(32'h10C, 32'h2000, 5'd3, 1, 1, 1, 3'd0); settle(); advance();
        idle(); b32.ws_allowin = 1'b0; b32.data_sram_data_ok = 1'b1; b32.data_sram_rdata = 32'hDEADBEEF;
        settle(); check("hold_valid", 64'(b32.ms_to_ws_valid), 64'd1); advance();
        idle(); b32.ws_allowin = 1'b0; settle();
        check("hold_result", 64'(b32.ms_final_result), 64'hDEADBEEF); advance();
        idle(); settle();
        check("hold_retire", 64'(b32.ms_final_result), 64'hDEADBEEF); advance();
        idle(); settle(); check("hold_empty", 64'(b32.ms_to_ws_valid), 64'd0); advance();

        // Flush in WAIT: the first response is stale, the second belongs to the new load.
        present(32'h110, 32'h3000, 5'd4, 1, 1, 1, 3'd0); settle(); advance();
        idle(); b32.flush = 1'b1; settle(); check("flush_valid", 64'(b32.ms_to_ws_valid), 64'd0); advance();
        idle(); present(32'h114, 32'h3004, 5'd6, 1, 1, 1, 3'd0); settle(); advance();
        idle(); b32.data_sram_data_ok = 1'b1; b32.data_sram_rdata = 32'h0000AAAA; settle();
        check("stale_valid", 64'(b32.ms_to_ws_valid), 64'd0);
        check("stale_pending", 64'(b32.mem_fwd_pending), 64'd1); advance();
        idle(); b32.data_sram_data_ok = 1'b1; b32.data_sram_rdata = 32'h00005555; settle();
        check("owned_valid", 64'(b32.ms_to_ws_valid), 64'd1);
        check("owned_result", 64'(b32.ms_final_result), 64'h5555); advance();

        // 64-bit data path: ld and wu.
        idle(); present64(64'h8, 3'd6); settle(); advance();
        idle(); b64.data_sram_data_ok = 1'b1; b64.data_sram_rdata = 64'h8000_0000_0000_0001; settle();
        check("ld64_valid", 64'(b64.ms_to_ws_valid), 64'd1);
        check("ld64_result", b64.ms_final_result, 64'h8000000000000001); advance();
        idle(); present64(64'hC, 3'd5); settle(); advance();
        idle(); b64.data_sram_data_ok = 1'b1; b64.data_sram_rdata = 64'h8000_0000_0000_0001; settle();
        check("wu64_result", b64.ms_final_result, 64'h0000000080000000);
        check("wu64_model", b64.ms_final_result, model_ext(64'h8000_0000_0000_0001, 64, 64'hC, 3'd5));
        advance();

        // Asynchronous reset in the middle of WAIT.
        idle(); present(32'h118, 32'h4000, 5'd2, 1, 1, 1, 3'd0); settle(); advance();
        idle(); settle();
        #2 resetn = 1'b0;
        #1;
        model_clear();
        check("arst_allowin", 64'(b32.ms_allowin), 64'd1);
        check("arst_valid", 64'(b32.ms_to_ws_valid), 64'd0);
        check("arst_waddr", 64'(b32.mem_waddr), 64'd0);
        check("arst_pending", 64'(b32.mem_fwd_pending), 64'd0);
        check("arst_pc", 64'(b32.ms_pc), 64'd0);
        advance();
        resetn = 1'b1;
        b32.data_sram_data_ok = 1'b1; b32.data_sram_rdata = 32'hFFFFFFFF;
        for (int i = 0; i < 3; i++) begin
            settle(); check("post_rst_no_retire", 64'(b32.ms_to_ws_valid), 64'd0); advance();
            b32.data_sram_data_ok = 1'b0;
        end

        // Randomized traffic.
        for (int cyc = 0; cyc < 3000; cyc++) begin
            idle();
            b32.ws_allowin = ($urandom_range(0, 9) < 7);
            if ($urandom_range(0, 9) < 6)
                present($urandom, $urandom, 5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)),
                        1'($urandom_range(0, 1)), ($urandom_range(0, 9) < 8), 3'($urandom_range(0, 7)));
            b32.data_sram_data_ok = (rq.size() > 0) && ($urandom_range(0, 9) < 4);
            b32.data_sram_rdata = $urandom;
            b32.flush = (cancelled_cnt() < 3) && ($urandom_range(0, 19) == 0);
            settle();
            advance();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
